// File: rtl/bcd_disp_pkg.sv
// Shared constants for the multiplexed 7-segment display: segment patterns,
// page encodings and the kinds of content a digit slot can carry.
package bcd_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Active-low gfedcba patterns for decimal digits 0..9
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    localparam logic PAGE_TIME = 1'b0;
    localparam logic PAGE_DATE = 1'b1;

    typedef enum logic [1:0] {
        DIGIT,
        DASH,
        BLANK
    } slot_kind_e;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; codes above 9 show a dash,
// and the blank flag overrides everything.
module bcd_to_seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] code,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (blank) begin
            seg = SEG_BLANK;
        end else if (code <= 4'd9) begin
            seg = SEG_DIGIT[code];
        end
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Six-digit multiplexed display driver with time/date pages; counter digits are
// snapshotted at each frame boundary so a rollover never tears a frame.
module bcd_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int PAGE_FRAMES = 500,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable_scan,
    input  logic [3:0] secbcd0,
    input  logic [3:0] secbcd1,
    input  logic [3:0] minbcd0,
    input  logic [3:0] minbcd1,
    input  logic [3:0] hourbcd0,
    input  logic [3:0] hourbcd1,
    input  logic [3:0] daybcd0,
    input  logic [3:0] daybcd1,
    input  logic [3:0] monthbcd,
    input  logic       page_sel,
    input  logic       auto_page,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       page,
    output logic       frame_start
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (PAGE_FRAMES > 1) ? $clog2(PAGE_FRAMES) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRM_MAX = FW'(PAGE_FRAMES - 1);

    logic [PW-1:0] prescaler;
    logic [2:0]    idx;
    logic [FW-1:0] frame_cnt;
    logic          page_q;
    logic [3:0]    sh_sec0, sh_sec1, sh_min0, sh_min1, sh_hour0, sh_hour1;
    logic [3:0]    sh_day0, sh_day1, sh_month;

    logic          tick;
    logic          boundary;
    slot_kind_e    kind;
    logic [3:0]    code;
    logic          dp_lit;
    logic [6:0]    seg_dec;

    assign tick     = enable_scan && (prescaler == PRE_MAX);
    assign boundary = tick && (idx == 3'd5);

    // Slot content comes only from the shadow copy, never the live inputs
    always_comb begin
        kind   = BLANK;
        code   = 4'd0;
        dp_lit = 1'b0;
        if (page_q == PAGE_TIME) begin
            kind   = DIGIT;
            dp_lit = ((idx == 3'd1) || (idx == 3'd3)) && !sh_sec0[0];
            case (idx)
                3'd0:    code = sh_sec0;
                3'd1:    code = sh_sec1;
                3'd2:    code = sh_min0;
                3'd3:    code = sh_min1;
                3'd4:    code = sh_hour0;
                3'd5: begin
                    code = sh_hour1;
                    if (BLANK_LZ && (sh_hour1 == 4'd0)) kind = BLANK;
                end
                default: kind = BLANK;
            endcase
        end else begin
            case (idx)
                3'd0: begin
                    kind = DIGIT;
                    code = sh_month;
                end
                3'd1: begin
                    kind = DASH;
                    code = 4'hA;
                end
                3'd2: begin
                    kind = DIGIT;
                    code = sh_day0;
                end
                3'd3: begin
                    kind = (BLANK_LZ && (sh_day1 == 4'd0)) ? BLANK : DIGIT;
                    code = sh_day1;
                end
                default: kind = BLANK;
            endcase
        end
    end

    bcd_to_seg u_dec (
        .code  (code),
        .blank (kind == BLANK),
        .seg   (seg_dec)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler   <= '0;
            idx         <= 3'd0;
            frame_cnt   <= '0;
            page_q      <= PAGE_TIME;
            sh_sec0     <= 4'd0;
            sh_sec1     <= 4'd0;
            sh_min0     <= 4'd0;
            sh_min1     <= 4'd0;
            sh_hour0    <= 4'd0;
            sh_hour1    <= 4'd0;
            sh_day0     <= 4'd0;
            sh_day1     <= 4'd0;
            sh_month    <= 4'd0;
            an          <= 6'b111111;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
            page        <= PAGE_TIME;
            frame_start <= 1'b0;
        end else begin
            frame_start <= boundary;
            if (enable_scan) begin
                prescaler <= (prescaler == PRE_MAX) ? '0 : prescaler + 1'b1;
            end
            if (tick) begin
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end
            if (boundary) begin
                sh_sec0  <= secbcd0;
                sh_sec1  <= secbcd1;
                sh_min0  <= minbcd0;
                sh_min1  <= minbcd1;
                sh_hour0 <= hourbcd0;
                sh_hour1 <= hourbcd1;
                sh_day0  <= daybcd0;
                sh_day1  <= daybcd1;
                sh_month <= monthbcd;
                if (auto_page) begin
                    if (frame_cnt == FRM_MAX) begin
                        frame_cnt <= '0;
                        page_q    <= ~page_q;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end else begin
                    page_q    <= page_sel;
                    frame_cnt <= '0;
                end
            end
            an   <= enable_scan ? ~(6'd1 << idx) : 6'b111111;
            seg  <= enable_scan ? seg_dec : SEG_BLANK;
            dp   <= ~(enable_scan && dp_lit);
            page <= page_q;
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Randomized and directed bench for bcd_display_scan against a frame-level
// reference model that tracks enabled cycles, page and snapshot digits.
module tb_bcd_display_scan;

    localparam int SD = 4;
    localparam int PF = 2;
    localparam int FL = 6 * SD;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable_scan;
    logic [3:0] secbcd0, secbcd1, minbcd0, minbcd1, hourbcd0, hourbcd1;
    logic [3:0] daybcd0, daybcd1, monthbcd;
    logic       page_sel;
    logic       auto_page;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       page;
    logic       frame_start;

    always #5 clock = ~clock;

    bcd_display_scan #(
        .SCAN_DIV    (SD),
        .PAGE_FRAMES (PF),
        .BLANK_LZ    (1'b1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable_scan (enable_scan),
        .secbcd0     (secbcd0),
        .secbcd1     (secbcd1),
        .minbcd0     (minbcd0),
        .minbcd1     (minbcd1),
        .hourbcd0    (hourbcd0),
        .hourbcd1    (hourbcd1),
        .daybcd0     (daybcd0),
        .daybcd1     (daybcd1),
        .monthbcd    (monthbcd),
        .page_sel    (page_sel),
        .auto_page   (auto_page),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .page        (page),
        .frame_start (frame_start)
    );

    // Reference state: enabled-cycle position in the frame, snapshot, page
    int         ecnt;
    int         fcnt;
    logic       mpage;
    logic [3:0] sh [0:8];
    logic [5:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_page, e_fs;
    int         n_chk = 0;
    int         n_pass = 0;

    logic [6:0] exp_first [0:5] = '{7'b0000010, 7'b0010010, 7'b0011001,
                                    7'b0110000, 7'b0100100, 7'b1111001};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [6:0] enc(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // sh order: sec0 sec1 min0 min1 hour0 hour1 day0 day1 month
    function automatic logic [6:0] ref_seg(input int s);
        if (mpage == 1'b0) begin
            if (s == 5 && sh[5] == 4'd0) return 7'b1111111;
            return enc(sh[s]);
        end
        case (s)
            0: return enc(sh[8]);
            1: return 7'b0111111;
            2: return enc(sh[6]);
            3: return (sh[7] == 4'd0) ? 7'b1111111 : enc(sh[7]);
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic step();
        int s;
        if (reset) begin
            e_an = 6'h3F; e_seg = 7'h7F; e_dp = 1'b1; e_page = 1'b0; e_fs = 1'b0;
            ecnt = 0; fcnt = 0; mpage = 1'b0;
            for (int i = 0; i < 9; i++) sh[i] = 4'd0;
        end else begin
            s      = ecnt / SD;
            e_an   = enable_scan ? (6'h3F ^ (6'd1 << s)) : 6'h3F;
            e_seg  = enable_scan ? ref_seg(s) : 7'h7F;
            e_dp   = !(enable_scan && mpage == 1'b0 && (s == 1 || s == 3) && sh[0][0] == 1'b0);
            e_page = mpage;
            e_fs   = enable_scan && (ecnt == FL - 1);
            if (enable_scan) ecnt = (ecnt + 1) % FL;
            if (e_fs) begin
                sh[0] = secbcd0;  sh[1] = secbcd1;  sh[2] = minbcd0;
                sh[3] = minbcd1;  sh[4] = hourbcd0; sh[5] = hourbcd1;
                sh[6] = daybcd0;  sh[7] = daybcd1;  sh[8] = monthbcd;
                if (auto_page) begin
                    fcnt = fcnt + 1;
                    if (fcnt == PF) begin
                        fcnt  = 0;
                        mpage = ~mpage;
                    end
                end else begin
                    mpage = page_sel;
                    fcnt  = 0;
                end
            end
        end
        @(posedge clock);
        #1;
        chk("an", an, e_an);
        chk("seg", seg, e_seg);
        chk("dp", dp, e_dp);
        chk("page", page, e_page);
        chk("frame_start", frame_start, e_fs);
    endtask

    task automatic wait_fs(input string tag);
        int k = 0;
        do begin
            step();
            k++;
        end while (frame_start !== 1'b1 && k < 200);
        chk(tag, frame_start, 1'b1);
    endtask

    initial begin
        reset = 1'b1; enable_scan = 1'b0; page_sel = 1'b0; auto_page = 1'b0;
        secbcd0 = 4'd6; secbcd1 = 4'd5; minbcd0 = 4'd4; minbcd1 = 4'd3;
        hourbcd0 = 4'd2; hourbcd1 = 4'd1; daybcd0 = 4'd7; daybcd1 = 4'd0; monthbcd = 4'd3;
        step();
        step();
        chk("rst_an", an, 6'b111111);
        chk("rst_seg", seg, 7'b1111111);
        chk("rst_dp", dp, 1'b1);
        chk("rst_fs", frame_start, 1'b0);

        // First frame of 12:34:56, seconds change mid-frame
        reset = 1'b0; enable_scan = 1'b1;
        wait_fs("fs_first");
        for (int s = 0; s < 6; s++) begin
            for (int c = 0; c < SD; c++) begin
                step();
                chk("walk_an", an, 6'h3F ^ (6'd1 << s));
                chk("walk_seg", seg, exp_first[s]);
                chk("walk_dp", dp, (s == 1 || s == 3) ? 1'b0 : 1'b1);
                if (s == 2 && c == 0) secbcd0 = 4'd7;
            end
        end
        wait_fs("fs_second");
        step();
        chk("new_sec", seg, 7'b1111000);

        // Date page
        page_sel = 1'b1;
        wait_fs("fs_date");
        step();
        chk("date_month", seg, 7'b0110000);
        chk("date_page", page, 1'b1);
        repeat (SD) step();
        chk("date_dash", seg, 7'b0111111);

        // Invalid hour digit back on the time page
        page_sel = 1'b0; hourbcd0 = 4'hC;
        wait_fs("fs_inval");
        wait_fs("fs_inval2");
        repeat (1 + 4 * SD) step();
        chk("inval_dash", seg, 7'b0111111);
        hourbcd0 = 4'd2;

        // Auto paging with page_sel noise
        auto_page = 1'b1;
        for (int f = 0; f < 8; f++) begin
            wait_fs("fs_auto");
            page_sel = 1'($urandom_range(0, 1));
        end
        auto_page = 1'b0;

        // enable dropped mid-frame, then resumed
        wait_fs("fs_en");
        repeat (9) step();
        enable_scan = 1'b0;
        repeat (10) begin
            step();
            chk("dark_an", an, 6'h3F);
        end
        enable_scan = 1'b1;
        step();
        chk("resume_an", an, 6'b111011);

        // Reset mid-frame
        repeat (3) step();
        reset = 1'b1;
        step();
        chk("mrst_an", an, 6'h3F);
        chk("mrst_seg", seg, 7'h7F);
        chk("mrst_page", page, 1'b0);
        reset = 1'b0;

        // Random traffic against the reference model
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                secbcd0  = 4'($urandom_range(0, 15)); secbcd1  = 4'($urandom_range(0, 9));
                minbcd0  = 4'($urandom_range(0, 9));  minbcd1  = 4'($urandom_range(0, 9));
                hourbcd0 = 4'($urandom_range(0, 15)); hourbcd1 = 4'($urandom_range(0, 2));
                daybcd0  = 4'($urandom_range(0, 9));  daybcd1  = 4'($urandom_range(0, 3));
                monthbcd = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 19) == 0) page_sel = ~page_sel;
            if ($urandom_range(0, 199) == 0) auto_page = ~auto_page;
            if (enable_scan) begin
                if ($urandom_range(0, 49) == 0) enable_scan = 1'b0;
            end else if ($urandom_range(0, 4) == 0) begin
                enable_scan = 1'b1;
            end
            reset = ($urandom_range(0, 599) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
